// File: rtl/sm83_bus_pkg.sv
// Shared constants and types for the SM83 bus responder slice.
package sm83_bus_pkg;

  // Register addresses on the high MMIO page
  localparam logic [15:0] IF_ADDR_DEF   = 16'hFF0F;
  localparam logic [15:0] BOOT_ADDR_DEF = 16'hFF50;

  // Implemented interrupt-flag bits (VBLANK..JOYPAD)
  localparam logic [7:0]  IRQ_MASK_DEF  = 8'h1F;

  // Interrupt bit positions inside IF
  typedef enum logic [2:0] {
    IRQ_VBLANK = 3'd0,
    IRQ_STAT   = 3'd1,
    IRQ_TIMER  = 3'd2,
    IRQ_SERIAL = 3'd3,
    IRQ_JOYPAD = 3'd4
  } irq_bit_e;

  // Which register (if any) the registered read path returns
  typedef enum logic [1:0] {
    RSEL_NONE = 2'd0,
    RSEL_IF   = 2'd1,
    RSEL_BOOT = 2'd2
  } rsel_e;

  // 0xFE00-0xFFFF (OAM, IO, HRAM, IE) is served by the MMIO fabric
  function automatic logic is_mmio(input logic [15:0] addr);
    return addr[15:9] == 7'h7F;
  endfunction

endpackage

// File: rtl/sm83_if_reg.sv
// Interrupt-flag register: peripheral edge capture, CPU acknowledge and
// CPU write, resolved per bit so a fresh peripheral edge always wins.
module sm83_if_reg
  import sm83_bus_pkg::*;
#(
  parameter logic [7:0] IRQ_MASK = IRQ_MASK_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic [7:0] periph_irq,
  input  logic [7:0] irq_ack,
  output logic [7:0] if_reg
);

  logic [7:0] periph_d;
  logic [7:0] if_next;

  // Per-bit priority: CPU write replaces, ack clears, new edge sets.
  // Unimplemented bits are forced to 0 so they never raise an interrupt.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      logic base;
      logic edge_set;
      assign base        = wr_en ? wr_data[gi] : if_reg[gi];
      assign edge_set    = periph_irq[gi] & ~periph_d[gi];
      assign if_next[gi] = IRQ_MASK[gi] & ((base & ~irq_ack[gi]) | edge_set);
    end
  endgenerate

  // Flag state and the previous peripheral level used for edge detection.
  // periph_d resets low so a level already high at release is taken once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_reg   <= 8'h00;
      periph_d <= 8'h00;
    end else begin
      if_reg   <= if_next;
      periph_d <= periph_irq;
    end
  end

endmodule

// File: rtl/sm83_bus_responder.sv
// Target-side responder for the SM83 bus: address decode, boot-ROM
// disable latch, write-commit pulse, registered read path and IF block.
module sm83_bus_responder
  import sm83_bus_pkg::*;
#(
  parameter logic [15:0] IF_ADDR   = IF_ADDR_DEF,
  parameter logic [15:0] BOOT_ADDR = BOOT_ADDR_DEF,
  parameter logic [7:0]  IRQ_MASK  = IRQ_MASK_DEF
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] A,
  input  logic [7:0]  D_IN,
  input  logic        RD,
  input  logic        WR,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  output logic        MMIO_REQ,
  output logic        IPL_REQ,
  input  logic [7:0]  PERIPH_IRQ,
  input  logic [7:0]  CPU_IRQ_ACK,
  output logic [7:0]  CPU_IRQ_TRIG
);

  logic       wr_d;
  logic       wr_pulse;
  logic       boot_off;
  logic       if_wr;
  logic [7:0] if_val;
  rsel_e      rsel;

  // Address decode: the only combinational outputs of the block
  assign MMIO_REQ = is_mmio(A);
  assign IPL_REQ  = (A[15:8] == 8'h00) && !boot_off;

  // One commit per WR high period, in the first cycle WR is seen high
  assign wr_pulse = WR && !wr_d;
  assign if_wr    = wr_pulse && (A == IF_ADDR);

  // WR history and the sticky boot-ROM disable; only reset clears it
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_d     <= 1'b0;
      boot_off <= 1'b0;
    end else begin
      wr_d <= WR;
      if (wr_pulse && (A == BOOT_ADDR) && D_IN[0])
        boot_off <= 1'b1;
    end
  end

  sm83_if_reg #(
    .IRQ_MASK (IRQ_MASK)
  ) u_if_reg (
    .clk        (CLK),
    .rst_n      (nRESET),
    .wr_en      (if_wr),
    .wr_data    (D_IN),
    .periph_irq (PERIPH_IRQ),
    .irq_ack    (CPU_IRQ_ACK),
    .if_reg     (if_val)
  );

  // IF is already registered, so the CPU sees no path from the inputs
  assign CPU_IRQ_TRIG = if_val;

  // Read target selection for this cycle's strobe
  always_comb begin
    rsel = RSEL_NONE;
    if (RD && (A == IF_ADDR))
      rsel = RSEL_IF;
    else if (RD && (A == BOOT_ADDR))
      rsel = RSEL_BOOT;
  end

  // Registered read data; uses pre-update state, so a same-cycle write
  // is not visible to the read that accompanies it
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      D_OUT <= 8'h00;
      D_OE  <= 1'b0;
    end else begin
      unique case (rsel)
        RSEL_IF: begin
          D_OUT <= if_val | ~IRQ_MASK;
          D_OE  <= 1'b1;
        end
        RSEL_BOOT: begin
          D_OUT <= 8'hFE | {7'd0, boot_off};
          D_OE  <= 1'b1;
        end
        default: begin
          D_OUT <= 8'h00;
          D_OE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm83_bus_responder.sv
// Self-checking bench for sm83_bus_responder: directed literal checks
// followed by randomized traffic compared every cycle against a model.
module tb_sm83_bus_responder;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [7:0]  D_IN = 8'h00;
  logic        RD = 1'b0;
  logic        WR = 1'b0;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic        MMIO_REQ;
  logic        IPL_REQ;
  logic [7:0]  PERIPH_IRQ = 8'h00;
  logic [7:0]  CPU_IRQ_ACK = 8'h00;
  logic [7:0]  CPU_IRQ_TRIG;

  int tests = 0;
  int fails = 0;

  sm83_bus_responder dut (
    .CLK          (CLK),
    .nRESET       (nRESET),
    .A            (A),
    .D_IN         (D_IN),
    .RD           (RD),
    .WR           (WR),
    .D_OUT        (D_OUT),
    .D_OE         (D_OE),
    .MMIO_REQ     (MMIO_REQ),
    .IPL_REQ      (IPL_REQ),
    .PERIPH_IRQ   (PERIPH_IRQ),
    .CPU_IRQ_ACK  (CPU_IRQ_ACK),
    .CPU_IRQ_TRIG (CPU_IRQ_TRIG)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // Flags are tracked as a plain byte; "newly asserted" is judged from the
  // value of each input on the previous clock edge.
  logic [7:0] m_if = 8'h00;
  logic       m_boot = 1'b0;
  logic       m_wr_last = 1'b0;
  logic [7:0] m_periph_last = 8'h00;
  logic [7:0] m_dout = 8'h00;
  logic       m_doe = 1'b0;

  function automatic logic [7:0] model_if_next(
    input logic [7:0] cur, input logic commit, input logic [15:0] addr,
    input logic [7:0] data, input logic [7:0] ack, input logic [7:0] lvl,
    input logic [7:0] last_lvl);
    logic [7:0] v;
    v = cur;
    if (commit && addr == 16'hFF0F) v = data;
    for (int b = 0; b < 8; b++) begin
      if (ack[b]) v[b] = 1'b0;
      if (lvl[b] && !last_lvl[b]) v[b] = 1'b1;
      if (b >= 5) v[b] = 1'b0;
    end
    return v;
  endfunction

  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      m_if          <= 8'h00;
      m_boot        <= 1'b0;
      m_wr_last     <= 1'b0;
      m_periph_last <= 8'h00;
      m_dout        <= 8'h00;
      m_doe         <= 1'b0;
    end else begin
      m_if <= model_if_next(m_if, WR && !m_wr_last, A, D_IN, CPU_IRQ_ACK,
                            PERIPH_IRQ, m_periph_last);
      if (WR && !m_wr_last && A == 16'hFF50 && D_IN[0]) m_boot <= 1'b1;
      m_wr_last     <= WR;
      m_periph_last <= PERIPH_IRQ;
      if (RD && A == 16'hFF0F) begin
        m_dout <= m_if + 8'hE0;   // top three bits are always 0 in m_if
        m_doe  <= 1'b1;
      end else if (RD && A == 16'hFF50) begin
        m_dout <= m_boot ? 8'hFF : 8'hFE;
        m_doe  <= 1'b1;
      end else begin
        m_dout <= 8'h00;
        m_doe  <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, mid-cycle when inputs are stable
  always @(negedge CLK) begin
    chk("model_dout", D_OUT, m_dout);
    chk("model_doe", {7'd0, D_OE}, {7'd0, m_doe});
    chk("model_trig", CPU_IRQ_TRIG, m_if);
    chk("model_mmio", {7'd0, MMIO_REQ}, {7'd0, A[15:9] == 7'h7F});
    chk("model_ipl", {7'd0, IPL_REQ}, {7'd0, (A < 16'h0100) && !m_boot});
  end

  // Advance one clock edge; leaves the caller 2 time units after the edge
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    cyc(3);
    chk("rst_trig", CPU_IRQ_TRIG, 8'h00);
    chk("rst_doe", {7'd0, D_OE}, 8'h00);
    chk("rst_dout", D_OUT, 8'h00);
    nRESET = 1'b1;
    cyc();

    // ---------------- decode ----------------
    A = 16'h0012; #1;
    chk("dec_ipl_0012", {7'd0, IPL_REQ}, 8'h01);
    chk("dec_mmio_0012", {7'd0, MMIO_REQ}, 8'h00);
    A = 16'hFF0F; #1;
    chk("dec_mmio_ff0f", {7'd0, MMIO_REQ}, 8'h01);
    chk("dec_ipl_ff0f", {7'd0, IPL_REQ}, 8'h00);
    A = 16'hFDFF; #1;
    chk("dec_mmio_fdff", {7'd0, MMIO_REQ}, 8'h00);
    A = 16'h0000;
    cyc();

    // ---------------- edge set, hold, ack ----------------
    PERIPH_IRQ = 8'h04;
    cyc();
    chk("timer_set", CPU_IRQ_TRIG, 8'h04);
    cyc(9);
    chk("timer_hold", CPU_IRQ_TRIG, 8'h04);
    CPU_IRQ_ACK = 8'h04;
    cyc();
    CPU_IRQ_ACK = 8'h00;
    chk("timer_ack", CPU_IRQ_TRIG, 8'h00);
    cyc(2);
    chk("timer_no_reset", CPU_IRQ_TRIG, 8'h00);
    PERIPH_IRQ = 8'h00;
    cyc();

    // ---------------- same-cycle priority ----------------
    PERIPH_IRQ = 8'h01;
    cyc();
    PERIPH_IRQ = 8'h00;
    cyc();
    chk("vblank_set", CPU_IRQ_TRIG, 8'h01);
    CPU_IRQ_ACK = 8'h01;
    PERIPH_IRQ  = 8'h01;
    cyc();
    CPU_IRQ_ACK = 8'h00;
    PERIPH_IRQ  = 8'h00;
    chk("ack_vs_edge", CPU_IRQ_TRIG, 8'h01);
    cyc();
    A = 16'hFF0F; D_IN = 8'h00; WR = 1'b1; PERIPH_IRQ = 8'h10;
    cyc();
    WR = 1'b0; PERIPH_IRQ = 8'h00;
    chk("write_vs_edge", CPU_IRQ_TRIG, 8'h10);
    cyc();

    // ---------------- held write, read back ----------------
    D_IN = 8'hFF; WR = 1'b1;
    cyc(3);
    WR = 1'b0;
    chk("held_write", CPU_IRQ_TRIG, 8'h1F);
    cyc();
    RD = 1'b1;
    cyc();
    RD = 1'b0;
    chk("rd_if_oe", {7'd0, D_OE}, 8'h01);
    chk("rd_if_data", D_OUT, 8'hFF);
    cyc();
    chk("rd_if_oe_drop", {7'd0, D_OE}, 8'h00);
    // a held WR must not recommit after an ack clears a bit
    WR = 1'b1;
    cyc();
    CPU_IRQ_ACK = 8'h01;
    cyc();
    CPU_IRQ_ACK = 8'h00;
    cyc();
    WR = 1'b0;
    chk("held_no_recommit", CPU_IRQ_TRIG, 8'h1E);
    cyc();

    // ---------------- boot latch ----------------
    A = 16'hFF50; D_IN = 8'h00; WR = 1'b1;
    cyc();
    WR = 1'b0; A = 16'h0012; #1;
    chk("boot_w0", {7'd0, IPL_REQ}, 8'h01);
    cyc();
    A = 16'hFF50; D_IN = 8'h01; WR = 1'b1;
    cyc();
    WR = 1'b0; A = 16'h0012; #1;
    chk("boot_w1", {7'd0, IPL_REQ}, 8'h00);
    A = 16'hFF50; RD = 1'b1;
    cyc();
    RD = 1'b0;
    chk("rd_boot", D_OUT, 8'hFF);
    D_IN = 8'h00; WR = 1'b1;
    cyc();
    WR = 1'b0; A = 16'h0012; #1;
    chk("boot_sticky", {7'd0, IPL_REQ}, 8'h00);
    cyc();

    // ---------------- asynchronous reset mid-operation ----------------
    A = 16'hFF0F; D_IN = 8'hFF; WR = 1'b1;
    cyc();
    WR = 1'b0; RD = 1'b1;
    cyc();
    chk("pre_rst_trig", CPU_IRQ_TRIG, 8'h1F);
    chk("pre_rst_oe", {7'd0, D_OE}, 8'h01);
    RD = 1'b0; A = 16'h0012;
    nRESET = 1'b0; #1;
    chk("async_trig", CPU_IRQ_TRIG, 8'h00);
    chk("async_oe", {7'd0, D_OE}, 8'h00);
    chk("async_dout", D_OUT, 8'h00);
    chk("async_ipl", {7'd0, IPL_REQ}, 8'h01);
    cyc();
    nRESET = 1'b1;
    cyc();

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0: A = 16'hFF0F;
        1: A = 16'hFF50;
        2: A = 16'(16'h0000 + $urandom_range(0, 255));
        default: A = 16'($urandom);
      endcase
      D_IN = 8'($urandom);
      RD   = ($urandom_range(0, 2) == 0);
      WR   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) PERIPH_IRQ = PERIPH_IRQ ^ 8'($urandom);
      CPU_IRQ_ACK = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
      nRESET = ($urandom_range(0, 399) != 0);
      cyc();
      nRESET = 1'b1;
    end
    WR = 1'b0; RD = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
